i2c_target_regfile: RTL

Parametrised I2C target with an internal byte-wide register file. It replaces the fixed 8-register target: register count, device address, input filter depth and a per-register read-only map are all parameters. Read-only registers return values from an external input. It sits on the same open-drain SDA/SCL net as the I2C initiator BFM in block and system benches, and exports register contents and write strobes to the surrounding logic.

---
 rtl/i2c_target_regfile.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a parametrised byte-wide register file, glitch-filtered bus inputs and
// per-register read-only map. Define I2C_TGT_GEN_CALL_EN to accept the general-call reset (0x00, 0x06).
module i2c_target_regfile #(
  parameter int                   NUM_REGS   = 8,
  parameter logic [6:0]           DEV_ADDR   = 7'h3C,
  parameter int                   FILT_DEPTH = 3,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_o,
  output logic                          sda_en_o,
  input  logic [8*NUM_REGS-1:0]         reg_ext_i,
  output logic [8*NUM_REGS-1:0]         reg_q,
  output logic                          wr_stb_o,
  output logic [$clog2(NUM_REGS)-1:0]   wr_idx_o,
  output logic                          busy_o
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_GC_CMD
  } state_t;

  // Channel 0 is SCL, channel 1 is SDA.
  logic [1:0] sync1, sync2, filt, filt_d;
  logic [2:0] filt_cnt [2];

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    tx;
  logic [PW-1:0] pointer;
  logic          ack_on;
  logic          rw;
  logic          gc;
  logic [7:0]    regs [NUM_REGS];
  logic [7:0]    ext  [NUM_REGS];

  logic          scl_rise, scl_fall, start_det, stop_det, sda_lvl;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic [PW-1:0] ptr_next;
  logic          gc_hit;

  assign sda_o = 1'b0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_map
    assign ext[g]            = reg_ext_i[8*g +: 8];
    assign reg_q[8*g +: 8]   = RO_MASK[g] ? 8'h00 : regs[g];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= '1;
      sync2       <= '1;
      filt        <= '1;
      filt_d      <= '1;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_d <= filt;
      // A new level is accepted only after FILT_DEPTH consecutive differing samples.
      for (int c = 0; c < 2; c++) begin
        if (sync2[c] == filt[c]) begin
          filt_cnt[c] <= '0;
        end else if (filt_cnt[c] == 3'(FILT_DEPTH - 1)) begin
          filt[c]     <= sync2[c];
          filt_cnt[c] <= '0;
        end else begin
          filt_cnt[c] <= filt_cnt[c] + 3'd1;
        end
      end
    end
  end

  assign scl_rise  =  filt[0] & ~filt_d[0];
  assign scl_fall  = ~filt[0] &  filt_d[0];
  assign start_det =  filt[0] &  filt_d[0] &  filt_d[1] & ~filt[1];
  assign stop_det  =  filt[0] &  filt_d[0] & ~filt_d[1] &  filt[1];
  assign sda_lvl   =  filt[1];

  assign rx_byte  = {shift[6:0], sda_lvl};
  assign rd_byte  = RO_MASK[pointer] ? ext[pointer] : regs[pointer];
  assign ptr_next = (pointer == PW'(NUM_REGS - 1)) ? '0 : pointer + PW'(1);

`ifdef I2C_TGT_GEN_CALL_EN
  assign gc_hit = (rx_byte == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= '0;
      pointer  <= '0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      gc       <= 1'b0;
      sda_en_o <= 1'b1;
      wr_stb_o <= 1'b0;
      wr_idx_o <= '0;
      busy_o   <= 1'b0;
      // NOTE: the register file is built from flops, so it takes the synchronous clear;
      // a RAM-inferred array could not be reset this way.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_stb_o <= 1'b0;
      if (stop_det) begin
        state    <= S_IDLE;
        sda_en_o <= 1'b1;
        busy_o   <= 1'b0;
        ack_on   <= 1'b0;
      end else if (start_det) begin
        state    <= S_ADDR;
        bit_cnt  <= '0;
        sda_en_o <= 1'b1;
        ack_on   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WR_DATA, S_GC_CMD: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == S_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state  <= S_ADDR_ACK;
                    rw     <= rx_byte[0];
                    gc     <= 1'b0;
                    busy_o <= 1'b1;
                  end else if (gc_hit) begin
                    state  <= S_ADDR_ACK;
                    rw     <= 1'b0;
                    gc     <= 1'b1;
                    busy_o <= 1'b1;
                  end else begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                  end
                end else if (state == S_PTR) begin
                  if (32'(rx_byte) < NUM_REGS) begin
                    pointer <= rx_byte[PW-1:0];
                    state   <= S_PTR_ACK;
                  end else begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                  end
                end else if (state == S_GC_CMD) begin
                  if (rx_byte == 8'h06) begin
                    state <= S_WR_ACK;
                  end else begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                  end
                end else begin
                  state <= S_WR_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // First SCL fall drives the ACK low, the second releases it and moves on.
          S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
            if (scl_rise && ack_on && state == S_WR_ACK) begin
              wr_stb_o <= 1'b0;
              if (gc) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (!RO_MASK[i]) regs[i] <= '0;
                pointer  <= '0;
                wr_stb_o <= 1'b1;
                wr_idx_o <= '0;
              end else begin
                if (!RO_MASK[pointer]) begin
                  regs[pointer] <= shift;
                  wr_stb_o      <= 1'b1;
                  wr_idx_o      <= pointer;
                end
                pointer <= ptr_next;
              end
            end
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on   <= 1'b1;
                sda_en_o <= 1'b0;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                if (state == S_ADDR_ACK && rw) begin
                  state    <= S_RD_DATA;
                  sda_en_o <= rd_byte[7];
                  tx       <= {rd_byte[6:0], 1'b0};
                end else begin
                  sda_en_o <= 1'b1;
                  if (state == S_PTR_ACK)       state <= S_WR_DATA;
                  else if (gc)                  state <= S_GC_CMD;
                  else if (state == S_ADDR_ACK) state <= S_PTR;
                  else                          state <= S_WR_DATA;
                end
              end
            end
          end

          S_RD_DATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_en_o <= 1'b1;
                bit_cnt  <= '0;
                state    <= S_RD_ACK;
              end else begin
                sda_en_o <= tx[7];
                tx       <= {tx[6:0], 1'b0};
              end
            end
          end

          // ack_on marks that the initiator acknowledged and another byte follows.
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                ack_on  <= 1'b1;
                pointer <= ptr_next;
              end else begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
              end
            end
            if (scl_fall && ack_on) begin
              ack_on   <= 1'b0;
              state    <= S_RD_DATA;
              sda_en_o <= rd_byte[7];
              tx       <= {rd_byte[6:0], 1'b0};
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
